// File: rtl/gate_ctrl_multi.sv
// Multi-channel barrier gate controller: per-channel travel FSM with a tick-based
// position counter, obstacle reversal, retry-limited fault lockout and registered motor outputs.
module gate_ctrl_multi #(
    parameter int NUM_GATES  = 2,
    parameter int MOVE_TICKS = 8,
    parameter int MAX_RETRY  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [2*NUM_GATES-1:0] traffic_state,
    input  logic [NUM_GATES-1:0]   obstacle,
    input  logic [NUM_GATES-1:0]   fault_clr,
    output logic [3*NUM_GATES-1:0] gate_state,
    output logic [NUM_GATES-1:0]   motor_up,
    output logic [NUM_GATES-1:0]   motor_down,
    output logic [NUM_GATES-1:0]   fault,
    output logic                   all_closed
);

    localparam logic [2:0] ST_CLOSED  = 3'b000;
    localparam logic [2:0] ST_OPENING = 3'b001;
    localparam logic [2:0] ST_OPEN    = 3'b010;
    localparam logic [2:0] ST_WAIT    = 3'b011;
    localparam logic [2:0] ST_CLOSING = 3'b100;
    localparam logic [2:0] ST_FAULT   = 3'b101;

    localparam int            PW        = $clog2(MOVE_TICKS + 1);
    localparam logic [PW-1:0] POS_FULL  = PW'(MOVE_TICKS);
    localparam logic [PW-1:0] POS_LAST  = PW'(MOVE_TICKS - 1);
    localparam logic [PW-1:0] POS_ONE   = PW'(1);
    localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);

    logic [2:0]    state_q [NUM_GATES];
    logic [2:0]    state_d [NUM_GATES];
    logic [PW-1:0] pos_q   [NUM_GATES];
    logic [PW-1:0] pos_d   [NUM_GATES];
    logic [3:0]    retry_q [NUM_GATES];
    logic [3:0]    retry_d [NUM_GATES];

    logic [NUM_GATES-1:0] red, green, yellow;
    logic [NUM_GATES-1:0] motor_up_q, motor_down_q, fault_q;
    logic                 all_closed_q, all_closed_d;

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_chan
        assign red[g]    = (traffic_state[2*g +: 2] == 2'b00);
        assign green[g]  = (traffic_state[2*g +: 2] == 2'b01);
        assign yellow[g] = traffic_state[2*g+1];
        assign gate_state[3*g +: 3] = state_q[g];
    end

    always_comb begin
        all_closed_d = 1'b1;
        for (int g = 0; g < NUM_GATES; g++) begin
            // NOTE: every next-state value starts as its current value so no path leaves it unassigned (no latch).
            state_d[g] = state_q[g];
            pos_d[g]   = pos_q[g];
            retry_d[g] = retry_q[g];
            case (state_q[g])
                ST_CLOSED: if (green[g]) state_d[g] = ST_OPENING;
                ST_OPENING: begin
                    if (red[g]) begin
                        state_d[g] = ST_CLOSING;
                    end else if (tick) begin
                        // >= also catches a reversal that started from the fully open position
                        if (pos_q[g] >= POS_LAST) begin
                            state_d[g] = ST_OPEN;
                            pos_d[g]   = POS_FULL;
                        end else begin
                            pos_d[g] = pos_q[g] + POS_ONE;
                        end
                    end
                end
                ST_OPEN: begin
                    if (yellow[g])   state_d[g] = ST_WAIT;
                    else if (red[g]) state_d[g] = ST_CLOSING;
                end
                ST_WAIT: begin
                    if (green[g])    state_d[g] = ST_OPEN;
                    else if (red[g]) state_d[g] = ST_CLOSING;
                end
                ST_CLOSING: begin
                    if (obstacle[g]) begin
                        retry_d[g] = retry_q[g] + 4'd1;
                        state_d[g] = (retry_q[g] + 4'd1 == RETRY_LIM) ? ST_FAULT : ST_OPENING;
                    end else if (green[g]) begin
                        state_d[g] = ST_OPENING;
                    end else if (tick) begin
                        if (pos_q[g] <= POS_ONE) begin
                            state_d[g] = ST_CLOSED;
                            pos_d[g]   = '0;
                            retry_d[g] = '0;
                        end else begin
                            pos_d[g] = pos_q[g] - POS_ONE;
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clr[g]) begin
                        state_d[g] = ST_OPENING;
                        retry_d[g] = '0;
                    end
                end
                default: state_d[g] = ST_CLOSING;
            endcase
            all_closed_d = all_closed_d & (state_d[g] == ST_CLOSED);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < NUM_GATES; g++) begin
                state_q[g] <= ST_CLOSED;
                pos_q[g]   <= '0;
                retry_q[g] <= '0;
            end
            motor_up_q   <= '0;
            motor_down_q <= '0;
            fault_q      <= '0;
            all_closed_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            for (int g = 0; g < NUM_GATES; g++) begin
                state_q[g]      <= state_d[g];
                pos_q[g]        <= pos_d[g];
                retry_q[g]      <= retry_d[g];
                motor_up_q[g]   <= (state_d[g] == ST_OPENING);
                motor_down_q[g] <= (state_d[g] == ST_CLOSING);
                fault_q[g]      <= (state_d[g] == ST_FAULT);
            end
            all_closed_q <= all_closed_d;
        end
    end

    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign fault      = fault_q;
    assign all_closed = all_closed_q;

endmodule

// File: doc/gate_ctrl_multi.md
Name: gate_ctrl_multi

Overview:
- Parametrised, clocked successor to the combinational traffic-to-gate mapper.
- Drives NUM_GATES independent barrier gates from per-channel traffic light state.
- Models gate travel time with a tick-based position counter.
- Adds obstacle-triggered re-open, a retry-limited fault lockout and per-gate motor commands.
- Sits between the traffic light FSMs and the gate motor drivers.

Parameters:
- NUM_GATES, 2, number of independent gate channels (1..8).
- MOVE_TICKS, 8, tick pulses for full travel between closed and open (2..255).
- MAX_RETRY, 3, obstacle reversals tolerated in one close attempt before FAULT (1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  one-cycle timebase strobe; position moves only on cycles with tick=1.
- traffic_state  in  2*NUM_GATES  per channel: 00 RED, 01 GREEN, 10 or 11 YELLOW; channel i uses bits [2i+1:2i].
- obstacle  in  NUM_GATES  per channel, high = object under the barrier.
- fault_clr  in  NUM_GATES  per channel, one-cycle fault acknowledge.
- gate_state  out  3*NUM_GATES  per channel state code, registered.
- motor_up  out  NUM_GATES  high while the channel is OPENING.
- motor_down  out  NUM_GATES  high while the channel is CLOSING.
- fault  out  NUM_GATES  high while the channel is in FAULT.
- all_closed  out  1  high when every channel is CLOSED.

Behaviour:
- Reset, synchronous and active-high, while rst=1 at a clock edge:
  - gate_state = CLOSED for every channel.
  - Position counter = 0; retry counter = 0.
  - motor_up, motor_down and fault = 0; all_closed = 1.
  - rst overrides every other input, including mid-travel and in FAULT.
- State codes:
  - CLOSED 000, OPENING 001, OPEN 010, WAIT 011, CLOSING 100, FAULT 101.
  - Codes 110 and 111 are unreachable; if entered, the channel goes to CLOSING on the next edge.
- Per-channel registers:
  - state, 3 bits.
  - pos, width clog2(MOVE_TICKS+1); 0 = fully closed, MOVE_TICKS = fully open.
  - retry, 4 bits.
- Channels are fully independent; no shared arbitration.
- Inputs are sampled at the clock edge. The new state, and motor outputs decoded from it, are visible one cycle after the input change.
- CLOSED:
  - GREEN -> OPENING.
  - RED or YELLOW -> stay.
- OPENING:
  - On tick, pos increments.
  - If pos == MOVE_TICKS-1 on a tick cycle, the channel enters OPEN on the same edge with pos = MOVE_TICKS.
  - RED -> CLOSING immediately, pos held; reversal costs no tick.
  - YELLOW or GREEN -> keep opening.
- OPEN:
  - YELLOW -> WAIT.
  - RED -> CLOSING.
  - GREEN -> stay.
- WAIT:
  - GREEN -> OPEN.
  - RED -> CLOSING.
  - YELLOW -> stay.
  - Gate stays physically open; pos unchanged.
- CLOSING, priority order:
  - (1) obstacle=1: if retry+1 == MAX_RETRY -> FAULT, otherwise -> OPENING; retry increments in both cases; pos held.
  - (2) GREEN -> OPENING, retry unchanged.
  - (3) On tick, pos decrements. If pos == 1 on a tick cycle, the channel enters CLOSED with pos = 0 and retry cleared.
  - YELLOW -> keep closing.
- Obstacle outside CLOSING is ignored.
- FAULT:
  - Motors off; pos frozen; traffic_state and obstacle are ignored.
  - fault_clr=1 -> OPENING, retry cleared.
  - rst clears it to CLOSED.
- Output decode, registered (all outputs update on the same edge as gate_state):
  - motor_up = (state == OPENING).
  - motor_down = (state == CLOSING).
  - fault = (state == FAULT).
  - motor_up and motor_down are never both high.
- Boundaries:
  - pos never exceeds MOVE_TICKS and never underflows below 0.
  - tick with no motion has no effect.
  - fault_clr outside FAULT is ignored.
  - all_closed is registered: the AND of (next state == CLOSED) across channels.

Test Plan (NUM_GATES=2, MOVE_TICKS=4, MAX_RETRY=2, tick every cycle):
- Reset, then hold ch0 GREEN → ch0 OPENING one cycle after GREEN is sampled, motor_up[0]=1. After 4 tick cycles: OPEN (010), motor_up[0]=0, all_closed=0. Ch1 stays CLOSED throughout.
- From OPEN, apply YELLOW then RED → WAIT (011) the next cycle, then CLOSING with motor_down[0]=1. CLOSED after 4 ticks; all_closed returns to 1.
- CLOSING with pos=2, assert obstacle[0] for 1 cycle → OPENING with pos held at 2 and retry=1. Keep RED → CLOSING again the next cycle.
- Second obstacle pulse in the same close attempt → FAULT (101), fault[0]=1, motors 0. GREEN ignored. fault_clr[0] pulse → OPENING, retry=0.
- Mid-OPENING (pos=2), switch to RED → CLOSING on the next edge with no position jump. Reaches CLOSED after 2 ticks.
- Assert rst while ch0 is CLOSING and ch1 is in FAULT → both CLOSED next edge, all outputs at reset values, all_closed=1.
